adaptive_threshold_writer: RTL
==============================

# adaptive_threshold_writer

Streaming binarisation stage that sits directly upstream of the 800x600 VGA controller and its 256x256x1-bit VRAM. It takes 8-bit grayscale pixels in raster order and compares each pixel against the mean of a horizontal sliding window plus an offset. Each binary result is presented on the controller's `write_x` / `write_y` / `write_value` port. The VRAM write enable is tied high, so these outputs must always carry a valid (address, value) pair and must hold between pixels.

## Interface
- `LOG_W`, 3: log2 of window width W (legal 1..5). The window is the current pixel plus the W-1 previous pixels of the same row.
- `OFFSET`, 4: 8-bit unsigned bias C. Pixel is white iff pix + C > window mean (exact, no truncation).

- `iCLK`  in  1  pixel clock (same 40 MHz clock as the VGA controller).
- `iRST_N`  in  1  reset. Asynchronous assert, active-low.
- `iPix_valid`  in  1  `iPix` / `iSOF` are accepted on this edge. Always accepted; no backpressure.
- `iPix`  in  8  grayscale pixel.
- `iSOF`  in  1  qualified by `iPix_valid`. This pixel is (0,0) of a new frame.
- `write_x`  out  8  VRAM column of current result.
- `write_y`  out  8  VRAM row of current result.
- `write_value`  out  1  binary result (1 = white).
- `oWrite_strobe`  out  1  one-cycle pulse when the write outputs take a new result.
- `oFrame_done`  out  1  one-cycle pulse coincident with the strobe for pixel (255,255).

## Operation
- **Coordinate counters `x`, `y`** (8 bit each):
  - Assigned on acceptance, then advance: x+1; at x=255, x→0 and y+1; at (255,255), wrap to (0,0).
  - An accepted pixel with `iSOF`=1 is forced to (0,0), regardless of the counters. The counters then continue from (1,0).
- **Window:**
  - W-entry × 8-bit shift register plus running sum `S`, width 8+LOG_W.
  - Normal pixel: S ← S + pix − oldest, shift pix in.
  - Pixel at x=0 (including SOF): all W entries ← pix, S ← pix<<LOG_W. This is edge replication; no data carries over between rows.
  - The window is updated only on accepted pixels. Idle cycles leave the window and counters untouched.
- **Decision:** value = ((pix<<LOG_W) + (OFFSET<<LOG_W)) > S.
  - Evaluated in 9+LOG_W bits unsigned, so there is no overflow.
  - Strict compare: a uniform region with OFFSET=0 gives 0.
  - S is the updated sum, so it includes the current pixel.
- **Output register:**
  - On strobe, `write_x`/`write_y`/`write_value` load the pipelined result.
  - Otherwise they hold their previous values. Re-writing the same VRAM cell is harmless.
- **No FSM beyond the pipeline.** Each of the 2 stage-valid bits is set by acceptance and cleared when not fed.

## Timing
- **Latency:**
  - Pixel accepted at edge t → outputs updated and `oWrite_strobe`=1 after edge t+2.
  - Stage 1 registers pix, x, y, SOF/row-start, and frame-end flag.
  - Stage 2 updates the window and sum and registers compare inputs.
  - Output registers load at t+2.
- **Throughput:** 1 pixel/clock sustained; arbitrary gaps allowed. Strobe count equals accepted-pixel count, in order.
- **`oFrame_done`:** asserts in the same cycle as the strobe carrying (255,255). A frame cut short by SOF produces no `oFrame_done`.
- **Reset values:** `write_x`=0, `write_y`=0, `write_value`=0, `oWrite_strobe`=0, `oFrame_done`=0. Counters, window, sum and stage-valid bits are 0.
  - Outputs go to these values immediately on `iRST_N` falling, with no clock needed.
- **Reset mid-frame:** in-flight pixels are discarded, with no strobe for them. The first pixel after release goes to (0,0), even without SOF.
- **Simultaneous events:**
  - SOF on a pixel whose counters are at (255,255): it is treated as (0,0). The prior frame is not counted done unless (255,255) was actually written.
  - SOF at x=0 is equivalent to row start.

## Test plan
1. **Uniform frame, OFFSET=4, LOG_W=3:** SOF, then 65536 pixels of 100, back-to-back.
   - Required: 65536 strobes, all `write_value`=1, addresses in raster order (0,0)…(255,255).
   - `oFrame_done` exactly once, at the strobe for (255,255), 2 cycles after the last pixel is accepted.
2. **Uniform frame, OFFSET=0:** all 100.
   - Required: every `write_value`=0 (strict compare).
3. **Step row, OFFSET=4, W=8:** row 0 is x0–7=0, x8–15=200, x16–255=0.
   - Required: x0–7 → 1, x8–15 → 1, x16–22 → 0, x23–255 → 1.
4. **Stalls:** insert 0–3 idle cycles randomly between pixels.
   - Required: results identical to back-to-back; outputs hold during gaps; strobe low during gaps; each strobe 2 cycles after its accepted pixel.
5. **Mid-frame SOF:** assert SOF on the pixel that would be (37,10).
   - Required: that pixel writes to (0,0) with the window reinitialised; the next pixel writes to (1,0).
   - No `oFrame_done` for the aborted frame.
6. **Async reset mid-frame:** pull `iRST_N` low between edges at (100,50).
   - Required: all outputs 0 before the next edge; no strobe for the 2 in-flight pixels; the first pixel after release writes to (0,0).

Source files
------------

// File: rtl/adaptive_threshold_writer.sv
// Streaming adaptive-threshold binariser feeding the VGA controller's VRAM write port.
// Each pixel is compared against the mean of a W-wide horizontal window (edge-replicated
// at row start) plus OFFSET; results appear 2 cycles after acceptance with a strobe.
module adaptive_threshold_writer #(
    parameter int unsigned LOG_W  = 3,
    parameter int unsigned OFFSET = 4
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iPix_valid,
    input  logic [7:0] iPix,
    input  logic       iSOF,
    output logic [7:0] write_x,
    output logic [7:0] write_y,
    output logic       write_value,
    output logic       oWrite_strobe,
    output logic       oFrame_done
);

    localparam int unsigned W  = 1 << LOG_W;
    localparam int unsigned SW = 8 + LOG_W;
    localparam int unsigned DW = 9 + LOG_W;
    localparam logic [7:0]  OFF8 = OFFSET[7:0];

    // Raster position counters (next coordinate to assign)
    logic [7:0] x_cnt, y_cnt;
    logic [7:0] cur_x, cur_y;

    // Stage 1 registers
    logic       s1_valid;
    logic [7:0] s1_pix, s1_x, s1_y;
    logic       s1_row_start, s1_last;

    // Stage 2 registers: window, running sum and compare inputs
    logic [7:0]    win [W];
    logic [SW-1:0] sum;
    logic [SW-1:0] next_sum;
    logic          s2_valid;
    logic [7:0]    s2_pix, s2_x, s2_y;
    logic          s2_last;
    logic          decide;

    // Coordinate assigned to the pixel on the input this cycle; SOF forces (0,0)
    always_comb begin
        cur_x = x_cnt;
        cur_y = y_cnt;
        if (iSOF) begin
            cur_x = 8'd0;
            cur_y = 8'd0;
        end
    end

    // Counters advance from the assigned coordinate; 8-bit wrap gives (255,255)->(0,0)
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            x_cnt <= 8'd0;
            y_cnt <= 8'd0;
        end else if (iPix_valid) begin
            x_cnt <= cur_x + 8'd1;
            y_cnt <= (cur_x == 8'hFF) ? cur_y + 8'd1 : cur_y;
        end
    end

    // Stage 1: capture pixel, coordinates, row-start and frame-end flags
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_valid     <= 1'b0;
            s1_pix       <= 8'd0;
            s1_x         <= 8'd0;
            s1_y         <= 8'd0;
            s1_row_start <= 1'b0;
            s1_last      <= 1'b0;
        end else begin
            s1_valid <= iPix_valid;
            if (iPix_valid) begin
                s1_pix       <= iPix;
                s1_x         <= cur_x;
                s1_y         <= cur_y;
                s1_row_start <= (cur_x == 8'd0);
                s1_last      <= (cur_x == 8'hFF) && (cur_y == 8'hFF);
            end
        end
    end

    // Updated window sum; row start replicates the pixel across the whole window.
    // Modular arithmetic is safe since the true result always fits in SW bits.
    always_comb begin
        next_sum = sum + SW'(s1_pix) - SW'(win[W-1]);
        if (s1_row_start) begin
            next_sum = SW'(s1_pix) << LOG_W;
        end
    end

    // Stage 2: shift window, update sum, register compare inputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < int'(W); i++) begin
                win[i] <= 8'd0;
            end
            sum      <= '0;
            s2_valid <= 1'b0;
            s2_pix   <= 8'd0;
            s2_x     <= 8'd0;
            s2_y     <= 8'd0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sum <= next_sum;
                if (s1_row_start) begin
                    for (int i = 0; i < int'(W); i++) begin
                        win[i] <= s1_pix;
                    end
                end else begin
                    for (int i = int'(W) - 1; i > 0; i--) begin
                        win[i] <= win[i-1];
                    end
                    win[0] <= s1_pix;
                end
                s2_pix  <= s1_pix;
                s2_x    <= s1_x;
                s2_y    <= s1_y;
                s2_last <= s1_last;
            end
        end
    end

    // Exact threshold test: (pix + C) * W > S, widened so nothing overflows
    always_comb begin
        decide = ((DW'(s2_pix) << LOG_W) + (DW'(OFF8) << LOG_W)) > DW'(sum);
    end

    // Output register: loads on strobe, otherwise holds the last VRAM write
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            write_x       <= 8'd0;
            write_y       <= 8'd0;
            write_value   <= 1'b0;
            oWrite_strobe <= 1'b0;
            oFrame_done   <= 1'b0;
        end else begin
            oWrite_strobe <= s2_valid;
            oFrame_done   <= s2_valid && s2_last;
            if (s2_valid) begin
                write_x     <= s2_x;
                write_y     <= s2_y;
                write_value <= decide;
            end
        end
    end

endmodule
